rv32imf_apu_resp_cmp: RTL and testbench



---
 rtl/rv32imf_apu_resp_cmp.sv | 189 ++++++++++++++++++
 tb/tb_rv32imf_apu_resp_cmp.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32imf_apu_resp_cmp.sv
// Non-arithmetic single-precision FP lane on the APU port: sign-inject,
// min/max, compare, classify and move, returned after a fixed latency.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   apu_req_i         request valid; apu_gnt_o mirrors it (no backpressure)
//   apu_op_i          opcode (0..9 legal, others raise NV with result 0)
//   apu_operands_i    operand slots; [0]=a, [1]=b
//   apu_rvalid_o      one-cycle pulse per request, LATENCY cycles later
//   apu_result_o      result, holds while apu_rvalid_o is low
//   apu_flags_o       {NV,DZ,OF,UF,NX}; only NV is ever set
//   busy_o            some pipeline stage holds a valid op
module rv32imf_apu_resp_cmp #(
    parameter int unsigned APU_NARGS_CPU    = 3,
    parameter int unsigned APU_WOP_CPU      = 6,
    parameter int unsigned APU_NUSFLAGS_CPU = 5,
    parameter int unsigned LATENCY          = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 apu_req_i,
    output logic                                 apu_gnt_o,
    input  logic [APU_WOP_CPU-1:0]               apu_op_i,
    input  logic [APU_NARGS_CPU-1:0][31:0]       apu_operands_i,
    output logic                                 apu_rvalid_o,
    output logic [31:0]                          apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]          apu_flags_o,
    output logic                                 busy_o
);

    localparam logic [APU_WOP_CPU-1:0] OP_FSGNJ  = APU_WOP_CPU'(0);
    localparam logic [APU_WOP_CPU-1:0] OP_FSGNJN = APU_WOP_CPU'(1);
    localparam logic [APU_WOP_CPU-1:0] OP_FSGNJX = APU_WOP_CPU'(2);
    localparam logic [APU_WOP_CPU-1:0] OP_FMIN   = APU_WOP_CPU'(3);
    localparam logic [APU_WOP_CPU-1:0] OP_FMAX   = APU_WOP_CPU'(4);
    localparam logic [APU_WOP_CPU-1:0] OP_FEQ    = APU_WOP_CPU'(5);
    localparam logic [APU_WOP_CPU-1:0] OP_FLT    = APU_WOP_CPU'(6);
    localparam logic [APU_WOP_CPU-1:0] OP_FLE    = APU_WOP_CPU'(7);
    localparam logic [APU_WOP_CPU-1:0] OP_FCLASS = APU_WOP_CPU'(8);
    localparam logic [APU_WOP_CPU-1:0] OP_FMV    = APU_WOP_CPU'(9);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        hs;
    logic [31:0] a;
    logic [31:0] b;
    logic        unused_args;

    assign apu_gnt_o   = apu_req_i;
    assign hs          = apu_req_i;
    assign a           = apu_operands_i[0];
    assign b           = apu_operands_i[1];
    assign unused_args = ^apu_operands_i;

    // Operand field decode
    logic a_nan, b_nan, a_snan, b_snan;
    logic a_inf, a_zero, a_sub;
    logic both_zero;

    assign a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    assign b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    assign a_snan    = a_nan && !a[22];
    assign b_snan    = b_nan && !b[22];
    assign a_inf     = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    assign a_zero    = (a[30:0] == '0);
    assign a_sub     = (a[30:23] == 8'h00) && (a[22:0] != '0);
    assign both_zero = a_zero && (b[30:0] == '0);

    // Monotonic integer key: negative values are bit-inverted so that
    // unsigned compare orders them, which also places -0 below +0.
    logic [31:0] key_a, key_b;
    logic        key_lt;
    logic        feq, flt;

    assign key_a  = a[31] ? ~a : {1'b1, a[30:0]};
    assign key_b  = b[31] ? ~b : {1'b1, b[30:0]};
    assign key_lt = key_a < key_b;
    assign feq    = (a == b) || both_zero;
    assign flt    = key_lt && !both_zero;

    logic [9:0] cls;

    always_comb begin
        cls = '0;
        if (a_nan) begin
            if (a[22]) cls[9] = 1'b1;
            else       cls[8] = 1'b1;
        end else if (a_inf) begin
            if (a[31]) cls[0] = 1'b1;
            else       cls[7] = 1'b1;
        end else if (a_zero) begin
            if (a[31]) cls[3] = 1'b1;
            else       cls[4] = 1'b1;
        end else if (a_sub) begin
            if (a[31]) cls[2] = 1'b1;
            else       cls[5] = 1'b1;
        end else begin
            if (a[31]) cls[1] = 1'b1;
            else       cls[6] = 1'b1;
        end
    end

    logic [31:0]                 res_d;
    logic                        nv;
    logic [APU_NUSFLAGS_CPU-1:0] flg_d;

    always_comb begin
        res_d = '0;
        nv    = 1'b0;
        unique case (apu_op_i)
            OP_FSGNJ:  res_d = {b[31], a[30:0]};
            OP_FSGNJN: res_d = {~b[31], a[30:0]};
            OP_FSGNJX: res_d = {a[31] ^ b[31], a[30:0]};
            OP_FMIN: begin
                if (a_nan && b_nan) res_d = QNAN;
                else if (a_nan)     res_d = b;
                else if (b_nan)     res_d = a;
                else                res_d = key_lt ? a : b;
                nv = a_snan || b_snan;
            end
            OP_FMAX: begin
                if (a_nan && b_nan) res_d = QNAN;
                else if (a_nan)     res_d = b;
                else if (b_nan)     res_d = a;
                else                res_d = key_lt ? b : a;
                nv = a_snan || b_snan;
            end
            OP_FEQ: begin
                res_d = {31'b0, feq && !(a_nan || b_nan)};
                nv    = a_snan || b_snan;
            end
            OP_FLT: begin
                res_d = {31'b0, flt && !(a_nan || b_nan)};
                nv    = a_nan || b_nan;
            end
            OP_FLE: begin
                res_d = {31'b0, (flt || feq) && !(a_nan || b_nan)};
                nv    = a_nan || b_nan;
            end
            OP_FCLASS: res_d = {22'b0, cls};
            OP_FMV:    res_d = a;
            default:   nv = 1'b1;
        endcase
        flg_d                     = '0;
        flg_d[APU_NUSFLAGS_CPU-1] = nv;
    end

    // Stage 0 captures the computed result; later stages only delay it.
    // Data registers load only behind a valid so the last stage holds
    // the previous result while no response is being returned.
    logic                        v_q   [LATENCY];
    logic [31:0]                 res_q [LATENCY];
    logic [APU_NUSFLAGS_CPU-1:0] flg_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                v_q[i]   <= 1'b0;
                res_q[i] <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            v_q[0] <= hs;
            if (hs) begin
                res_q[0] <= res_d;
                flg_q[0] <= flg_d;
            end
            for (int i = 1; i < int'(LATENCY); i++) begin
                v_q[i] <= v_q[i-1];
                if (v_q[i-1]) begin
                    res_q[i] <= res_q[i-1];
                    flg_q[i] <= flg_q[i-1];
                end
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            busy_o = busy_o | v_q[i];
        end
    end

    assign apu_rvalid_o = v_q[LATENCY-1];
    assign apu_result_o = res_q[LATENCY-1];
    assign apu_flags_o  = flg_q[LATENCY-1];

endmodule

// File: tb/tb_rv32imf_apu_resp_cmp.sv
// Self-checking bench for rv32imf_apu_resp_cmp.
// Reference model works on real values and IEEE fields.
module tb_rv32imf_apu_resp_cmp;

    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req = 1'b0;
    logic             gnt;
    logic [5:0]       op = '0;
    logic [2:0][31:0] opnds = '0;
    logic             rvalid;
    logic [31:0]      result;
    logic [4:0]       flags;
    logic             busy;

    rv32imf_apu_resp_cmp #(
        .APU_NARGS_CPU(3),
        .APU_WOP_CPU(6),
        .APU_NUSFLAGS_CPU(5),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .apu_req_i(req),
        .apu_gnt_o(gnt),
        .apu_op_i(op),
        .apu_operands_i(opnds),
        .apu_rvalid_o(rvalid),
        .apu_result_o(result),
        .apu_flags_o(flags),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] last_res = '0;
    logic [4:0]  last_flg = '0;

    logic        s_req [64];
    logic [5:0]  s_op  [64];
    logic [31:0] s_a   [64];
    logic [31:0] s_b   [64];
    logic        obs_v [80];
    logic [31:0] obs_r [80];
    logic [4:0]  obs_f [80];
    logic        obs_b [80];

    function automatic real f2r(input logic [31:0] x);
        real m;
        int  e;
        e = int'(x[30:23]);
        if (e == 255)    m = 1.0e300;
        else if (e == 0) m = real'(x[22:0]) * (2.0 ** -149);
        else             m = real'({1'b1, x[22:0]}) * (2.0 ** (e - 150));
        return x[31] ? -m : m;
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic logic is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

    function automatic void model(input logic [5:0] o, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f);
        real ra, rb;
        logic an, bn, nv;
        int idx;
        an = is_nan(a);
        bn = is_nan(b);
        ra = f2r(a);
        rb = f2r(b);
        r  = 0;
        nv = 0;
        case (o)
            0: r = {b[31], a[30:0]};
            1: r = {~b[31], a[30:0]};
            2: r = {a[31] ^ b[31], a[30:0]};
            3, 4: begin
                nv = is_snan(a) || is_snan(b);
                if (an && bn)   r = 32'h7FC0_0000;
                else if (an)    r = b;
                else if (bn)    r = a;
                else if (o == 3) r = (ra < rb) ? a : (rb < ra) ? b : (a[31] ? a : b);
                else             r = (ra > rb) ? a : (rb > ra) ? b : (a[31] ? b : a);
            end
            5: begin
                nv = is_snan(a) || is_snan(b);
                r  = (!an && !bn && ra == rb) ? 1 : 0;
            end
            6: begin
                nv = an || bn;
                r  = (!an && !bn && ra < rb) ? 1 : 0;
            end
            7: begin
                nv = an || bn;
                r  = (!an && !bn && ra <= rb) ? 1 : 0;
            end
            8: begin
                if (an)                                      idx = a[22] ? 9 : 8;
                else if (a[30:23] == 8'hFF)                  idx = a[31] ? 0 : 7;
                else if (a[30:0] == 0)                       idx = a[31] ? 3 : 4;
                else if (a[30:23] == 0)                      idx = a[31] ? 2 : 5;
                else                                         idx = a[31] ? 1 : 6;
                r = 32'd1 << idx;
            end
            9: r = a;
            default: nv = 1;
        endcase
        f = {nv, 4'b0000};
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] pool [12];
        pool = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0000, 32'h7FA0_0000, 32'hFFC0_0001, 32'h0000_0001,
                 32'h807F_FFFF, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000};
        if ($urandom_range(0, 2) == 0) return $urandom;
        return pool[$urandom_range(0, 11)];
    endfunction

    // Drives s_* for n cycles, then idles to drain; records outputs.
    task automatic run(input int n);
        for (int k = 0; k < n + LAT + 1; k++) begin
            @(negedge clk);
            if (k < n) begin
                req      = s_req[k];
                op       = s_op[k];
                opnds[0] = s_a[k];
                opnds[1] = s_b[k];
            end else begin
                req      = 1'b0;
                op       = 6'($urandom);
                opnds[0] = $urandom;
                opnds[1] = $urandom;
            end
            opnds[2] = $urandom;
            @(posedge clk);
            #1;
            obs_v[k] = rvalid;
            obs_r[k] = result;
            obs_f[k] = flags;
            obs_b[k] = busy;
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (rvalid !== 1'b0 || result !== 32'h0 || flags !== 5'h0 || busy !== 1'b0 || gnt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b r=%h f=%b busy=%b gnt=%b, want all 0",
                     rvalid, result, flags, busy, gnt);
        end
        req = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 1'b1) begin
            n_err++;
            $display("FAIL gnt_follows_req: got %b want 1", gnt);
        end
        req = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 1'b0) begin
            n_err++;
            $display("FAIL gnt_drop: got %b want 0", gnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fmv_latency();
        int n = 1;
        s_req[0] = 1; s_op[0] = 9; s_a[0] = 32'h3F80_0000; s_b[0] = $urandom;
        run(n);
        for (int k = 0; k < n + LAT + 1; k++) begin
            logic ev;
            ev = (k == LAT - 1);
            n_cmp++;
            if (obs_v[k] !== ev) begin
                n_err++;
                $display("FAIL fmv_rvalid cyc %0d: got %b want %b", k, obs_v[k], ev);
            end
            if (k >= LAT - 1) begin
                n_cmp++;
                if (obs_r[k] !== 32'h3F80_0000 || obs_f[k] !== 5'h0) begin
                    n_err++;
                    $display("FAIL fmv_result cyc %0d: got %h/%b want 3f800000/00000",
                             k, obs_r[k], obs_f[k]);
                end
            end
        end
        last_res = 32'h3F80_0000;
        last_flg = 5'h0;
    endtask

    task automatic test_minmax();
        int n = 6;
        s_op = '{default: 0};
        s_req[0] = 1; s_op[0] = 3; s_a[0] = 32'h7FA0_0000; s_b[0] = 32'h4000_0000;
        s_req[1] = 1; s_op[1] = 4; s_a[1] = 32'h7FC0_0000; s_b[1] = 32'hFFC0_0001;
        s_req[2] = 1; s_op[2] = 3; s_a[2] = 32'h0000_0000; s_b[2] = 32'h8000_0000;
        s_req[3] = 1; s_op[3] = 4; s_a[3] = 32'h8000_0000; s_b[3] = 32'h0000_0000;
        s_req[4] = 1; s_op[4] = 3; s_a[4] = 32'hBF80_0000; s_b[4] = 32'h3F80_0000;
        s_req[5] = 1; s_op[5] = 4; s_a[5] = 32'h4000_0000; s_b[5] = 32'h7FC0_0000;
        run(n);
        n_cmp++;
        if (obs_r[LAT-1] !== 32'h4000_0000 || obs_f[LAT-1] !== 5'b10000) begin
            n_err++;
            $display("FAIL fmin_snan: got %h/%b want 40000000/10000", obs_r[LAT-1], obs_f[LAT-1]);
        end
        n_cmp++;
        if (obs_r[LAT] !== 32'h7FC0_0000) begin
            n_err++;
            $display("FAIL fmax_both_nan: got %h want 7fc00000", obs_r[LAT]);
        end
        n_cmp++;
        if (obs_r[LAT+1] !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL fmin_zero: got %h want 80000000", obs_r[LAT+1]);
        end
        for (int k = 0; k < n + LAT + 1; k++) begin
            int i;
            logic ev;
            logic [31:0] er;
            logic [4:0] ef;
            i  = k - LAT + 1;
            ev = (i >= 0 && i < n) ? s_req[i] : 1'b0;
            if (ev) begin
                model(s_op[i], s_a[i], s_b[i], er, ef);
                last_res = er; last_flg = ef;
            end else begin
                er = last_res; ef = last_flg;
            end
            n_cmp++;
            if (obs_v[k] !== ev || obs_r[k] !== er || obs_f[k] !== ef) begin
                n_err++;
                $display("FAIL minmax cyc %0d: got v=%b %h/%b want v=%b %h/%b",
                         k, obs_v[k], obs_r[k], obs_f[k], ev, er, ef);
            end
        end
    endtask

    task automatic test_compare();
        int n = 6;
        s_req[0] = 1; s_op[0] = 6; s_a[0] = 32'h7FC0_0000; s_b[0] = 32'h0000_0000;
        s_req[1] = 1; s_op[1] = 5; s_a[1] = 32'h7FC0_0000; s_b[1] = 32'h0000_0000;
        s_req[2] = 1; s_op[2] = 7; s_a[2] = 32'h8000_0000; s_b[2] = 32'h0000_0000;
        s_req[3] = 1; s_op[3] = 5; s_a[3] = 32'h0000_0000; s_b[3] = 32'h8000_0000;
        s_req[4] = 1; s_op[4] = 6; s_a[4] = 32'h8000_0000; s_b[4] = 32'h0000_0000;
        s_req[5] = 1; s_op[5] = 5; s_a[5] = 32'h7FA0_0000; s_b[5] = 32'h7FA0_0000;
        run(n);
        n_cmp++;
        if (obs_r[LAT-1] !== 32'h0 || obs_f[LAT-1] !== 5'b10000) begin
            n_err++;
            $display("FAIL flt_qnan: got %h/%b want 0/10000", obs_r[LAT-1], obs_f[LAT-1]);
        end
        n_cmp++;
        if (obs_r[LAT] !== 32'h0 || obs_f[LAT] !== 5'b00000) begin
            n_err++;
            $display("FAIL feq_qnan: got %h/%b want 0/00000", obs_r[LAT], obs_f[LAT]);
        end
        n_cmp++;
        if (obs_r[LAT+1] !== 32'h1) begin
            n_err++;
            $display("FAIL fle_zero: got %h want 1", obs_r[LAT+1]);
        end
        for (int k = 0; k < n + LAT + 1; k++) begin
            int i;
            logic ev;
            logic [31:0] er;
            logic [4:0] ef;
            i  = k - LAT + 1;
            ev = (i >= 0 && i < n) ? s_req[i] : 1'b0;
            if (ev) begin
                model(s_op[i], s_a[i], s_b[i], er, ef);
                last_res = er; last_flg = ef;
            end else begin
                er = last_res; ef = last_flg;
            end
            n_cmp++;
            if (obs_v[k] !== ev || obs_r[k] !== er || obs_f[k] !== ef) begin
                n_err++;
                $display("FAIL compare cyc %0d: got v=%b %h/%b want v=%b %h/%b",
                         k, obs_v[k], obs_r[k], obs_f[k], ev, er, ef);
            end
        end
    endtask

    task automatic test_fclass();
        logic [31:0] want [3];
        int n = 3;
        want = '{32'h001, 32'h020, 32'h200};
        s_req[0] = 1; s_op[0] = 8; s_a[0] = 32'hFF80_0000; s_b[0] = $urandom;
        s_req[1] = 1; s_op[1] = 8; s_a[1] = 32'h0000_0001; s_b[1] = $urandom;
        s_req[2] = 1; s_op[2] = 8; s_a[2] = 32'h7FC0_0000; s_b[2] = $urandom;
        run(n);
        for (int j = 0; j < n; j++) begin
            n_cmp++;
            if (obs_v[j+LAT-1] !== 1'b1 || obs_r[j+LAT-1] !== want[j] || obs_f[j+LAT-1] !== 5'h0) begin
                n_err++;
                $display("FAIL fclass_%0d: got v=%b %h/%b want v=1 %h/00000",
                         j, obs_v[j+LAT-1], obs_r[j+LAT-1], obs_f[j+LAT-1], want[j]);
            end
        end
        last_res = want[n-1];
        last_flg = 5'h0;
    endtask

    task automatic test_back_to_back();
        int n = 5;
        for (int i = 0; i < n; i++) begin
            s_req[i] = 1;
            s_op[i]  = 6'($urandom_range(0, 9));
            s_a[i]   = pick_operand();
            s_b[i]   = pick_operand();
        end
        run(n);
        for (int k = 0; k < n + LAT + 1; k++) begin
            int i;
            logic ev, eb;
            logic [31:0] er;
            logic [4:0] ef;
            i  = k - LAT + 1;
            ev = (i >= 0 && i < n) ? s_req[i] : 1'b0;
            eb = 1'b0;
            for (int j = k - LAT + 1; j <= k; j++)
                if (j >= 0 && j < n && s_req[j]) eb = 1'b1;
            if (ev) begin
                model(s_op[i], s_a[i], s_b[i], er, ef);
                last_res = er; last_flg = ef;
            end else begin
                er = last_res; ef = last_flg;
            end
            n_cmp++;
            if (obs_v[k] !== ev || obs_r[k] !== er || obs_f[k] !== ef) begin
                n_err++;
                $display("FAIL b2b cyc %0d: got v=%b %h/%b want v=%b %h/%b",
                         k, obs_v[k], obs_r[k], obs_f[k], ev, er, ef);
            end
            n_cmp++;
            if (obs_b[k] !== eb) begin
                n_err++;
                $display("FAIL b2b_busy cyc %0d: got %b want %b", k, obs_b[k], eb);
            end
        end
    endtask

    task automatic test_random();
        int n = 60;
        for (int i = 0; i < n; i++) begin
            s_req[i] = ($urandom_range(0, 9) < 7);
            s_op[i]  = ($urandom_range(0, 15) == 0) ? 6'($urandom) : 6'($urandom_range(0, 9));
            s_a[i]   = pick_operand();
            s_b[i]   = pick_operand();
        end
        run(n);
        for (int k = 0; k < n + LAT + 1; k++) begin
            int i;
            logic ev, eb;
            logic [31:0] er;
            logic [4:0] ef;
            i  = k - LAT + 1;
            ev = (i >= 0 && i < n) ? s_req[i] : 1'b0;
            eb = 1'b0;
            for (int j = k - LAT + 1; j <= k; j++)
                if (j >= 0 && j < n && s_req[j]) eb = 1'b1;
            if (ev) begin
                model(s_op[i], s_a[i], s_b[i], er, ef);
                last_res = er; last_flg = ef;
            end else begin
                er = last_res; ef = last_flg;
            end
            n_cmp++;
            if (obs_v[k] !== ev || obs_r[k] !== er || obs_f[k] !== ef || obs_b[k] !== eb) begin
                n_err++;
                $display("FAIL random cyc %0d op %0d: got v=%b %h/%b busy=%b want v=%b %h/%b busy=%b",
                         k, (i >= 0 && i < n) ? s_op[i] : 0, obs_v[k], obs_r[k], obs_f[k],
                         obs_b[k], ev, er, ef, eb);
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        req = 1; op = 9; opnds[0] = 32'h1234_5678; opnds[1] = $urandom;
        @(posedge clk);
        @(negedge clk);
        req = 1; op = 0; opnds[0] = 32'h3F80_0000; opnds[1] = 32'h8000_0000;
        @(posedge clk);
        #1;
        req   = 0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rvalid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || flags !== 5'h0) begin
            n_err++;
            $display("FAIL midflight_reset: got v=%b busy=%b %h/%b want 0 0 0/0",
                     rvalid, busy, result, flags);
        end
        last_res = '0;
        last_flg = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (rvalid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_drop cyc %0d: got v=%b busy=%b want 0 0", k, rvalid, busy);
            end
        end
    endtask

    task automatic test_illegal_op();
        int n = 1;
        s_req[0] = 1; s_op[0] = 6'h3F; s_a[0] = 32'h3F80_0000; s_b[0] = 32'h4000_0000;
        run(n);
        for (int k = 0; k < n + LAT + 1; k++) begin
            logic ev;
            ev = (k == LAT - 1);
            n_cmp++;
            if (obs_v[k] !== ev) begin
                n_err++;
                $display("FAIL illegal_rvalid cyc %0d: got %b want %b", k, obs_v[k], ev);
            end
            if (k >= LAT - 1) begin
                n_cmp++;
                if (obs_r[k] !== 32'h0 || obs_f[k] !== 5'b10000) begin
                    n_err++;
                    $display("FAIL illegal_result cyc %0d: got %h/%b want 0/10000",
                             k, obs_r[k], obs_f[k]);
                end
            end
        end
        last_res = '0;
        last_flg = 5'b10000;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            s_req[i] = 0; s_op[i] = 0; s_a[i] = 0; s_b[i] = 0;
        end
        test_reset();
        test_fmv_latency();
        test_minmax();
        test_compare();
        test_fclass();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_illegal_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
